// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream
// ------------------------------------------------------------------
// Read-side drain stage that sits directly after a synchronous FIFO.
// It issues fifo_rd_en, absorbs the FIFO's one-cycle read latency, and
// re-presents each word on a valid/ready stream through a 2-entry
// in-order skid buffer, so no word is lost under backpressure. It also
// counts delivered words and records FIFO underflow events.
//
// Handshake: a word transfers on every posedge where m_valid and m_ready
// are both 1. Once m_valid is high it stays high, and m_data stays
// stable, until that transfer happens. m_ready may change freely.
//
// Ports:
//   clk, rst        single clock; synchronous active-high reset
//   enable          allow new FIFO reads
//   fifo_data_out   FIFO read data, valid the cycle after an accepted rd_en
//   fifo_empty      FIFO empty flag
//   fifo_underflow  FIFO underflow flag (only honoured in in-flight cycles)
//   fifo_rd_en      read request to the FIFO
//   m_data/m_valid  stream output (head of the skid buffer)
//   m_ready         downstream accept
//   busy            FSM is not IDLE
//   rd_count        words delivered, wraps modulo 2^CNT_WIDTH
//   underflow_seen  sticky underflow indication, cleared only by rst
//   state_dbg       current FSM state (IDLE=0, RUN=1, DRAIN=2)
//   m_parity        even parity of m_data (only when FIFO_RD_STREAM_PARITY_EN
//                   is defined)
//
// Build option: define FIFO_RD_STREAM_PARITY_EN to add m_parity and the
// per-entry parity storage.
// ------------------------------------------------------------------
module fifo_rd_stream #(
  parameter int DATA_WIDTH = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] fifo_data_out,
  input  logic                  fifo_empty,
  input  logic                  fifo_underflow,
  output logic                  fifo_rd_en,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  rd_count,
  output logic                  underflow_seen,
  output logic [1:0]            state_dbg
`ifdef FIFO_RD_STREAM_PARITY_EN
  ,
  output logic                  m_parity
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t                state;
  logic [1:0]            occ;
  logic                  inflight;
  logic [DATA_WIDTH-1:0] buf0;
  logic [DATA_WIDTH-1:0] buf1;

  logic                  pop;
  logic                  capture;
  logic [2:0]            pending;

  assign m_valid   = (occ != 2'd0);
  assign m_data    = buf0;
  assign pop       = m_valid & m_ready;
  assign capture   = inflight & ~fifo_underflow;
  assign busy      = (state != IDLE);
  assign state_dbg = state;

  // Credit check: words already buffered plus the one in flight, minus the
  // one leaving this cycle, must leave room for another word in the
  // 2-entry buffer. This is what keeps occ from ever exceeding 2.
  assign pending    = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
  assign fifo_rd_en = enable & ~fifo_empty & ~rst & (pending < 3'd2);

`ifdef FIFO_RD_STREAM_PARITY_EN
  logic par0;
  logic par1;
  logic din_par;

  assign din_par  = ^fifo_data_out;
  assign m_parity = par0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      occ            <= 2'd0;
      inflight       <= 1'b0;
      buf0           <= '0;
      buf1           <= '0;
      rd_count       <= '0;
      underflow_seen <= 1'b0;
`ifdef FIFO_RD_STREAM_PARITY_EN
      par0           <= 1'b0;
      par1           <= 1'b0;
`endif
    end else begin
      inflight <= fifo_rd_en;

      // A read that returned on an underflow cycle carries no real word.
      if (inflight && fifo_underflow) begin
        underflow_seen <= 1'b1;
      end

      if (pop) begin
        rd_count <= rd_count + CNT_WIDTH'(1);
      end

      // Skid buffer: buf0 is the head, buf1 the second entry.
      case ({pop, capture})
        2'b10: begin
          buf0 <= buf1;
`ifdef FIFO_RD_STREAM_PARITY_EN
          par0 <= par1;
`endif
          occ  <= occ - 2'd1;
        end
        2'b01: begin
          if (occ == 2'd0) begin
            buf0 <= fifo_data_out;
`ifdef FIFO_RD_STREAM_PARITY_EN
            par0 <= din_par;
`endif
          end else begin
            buf1 <= fifo_data_out;
`ifdef FIFO_RD_STREAM_PARITY_EN
            par1 <= din_par;
`endif
          end
          occ <= occ + 2'd1;
        end
        2'b11: begin
          // Occupancy is unchanged; the new word takes the tail slot.
          if (occ == 2'd1) begin
            buf0 <= fifo_data_out;
`ifdef FIFO_RD_STREAM_PARITY_EN
            par0 <= din_par;
`endif
          end else begin
            buf0 <= buf1;
            buf1 <= fifo_data_out;
`ifdef FIFO_RD_STREAM_PARITY_EN
            par0 <= par1;
            par1 <= din_par;
`endif
          end
        end
        default: ;
      endcase

      case (state)
        IDLE: begin
          if (enable) state <= RUN;
        end
        RUN: begin
          if (!enable) begin
            if ((occ != 2'd0) || inflight) state <= DRAIN;
            else                           state <= IDLE;
          end
        end
        DRAIN: begin
          if (enable)                                state <= RUN;
          else if ((occ == 2'd0) && !inflight)       state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
